// File: rtl/aes_pkg.sv
// AES MixColumns shared definitions: widths, column type, FSM encoding, GF(2^8) helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef logic [AES_COL_W-1:0] aes_col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mixcol_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // 9 = 8+1
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  // b = 8+2+1
  function automatic logic [7:0] gf_mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  // d = 8+4+1
  function automatic logic [7:0] gf_muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  // e = 8+4+2
  function automatic logic [7:0] gf_mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// One-column (Inv)MixColumns transform; inverse path only exists with AES_MIXCOL_INV_EN.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the result is captured.
module aes_mixcol_col
  import aes_pkg::*;
(
  input  aes_col_t col,
  input  logic     inv,
  output aes_col_t col_out
);

  logic [7:0] w_b0, w_b1, w_b2, w_b3;
  aes_col_t   w_fwd;

  // b0 is the most significant byte of the column
  assign w_b0 = col[31:24];
  assign w_b1 = col[23:16];
  assign w_b2 = col[15:8];
  assign w_b3 = col[7:0];

  assign w_fwd = {gf_mul2(w_b0) ^ gf_mul3(w_b1) ^ w_b2          ^ w_b3,
                  w_b0          ^ gf_mul2(w_b1) ^ gf_mul3(w_b2) ^ w_b3,
                  w_b0          ^ w_b1          ^ gf_mul2(w_b2) ^ gf_mul3(w_b3),
                  gf_mul3(w_b0) ^ w_b1          ^ w_b2          ^ gf_mul2(w_b3)};

`ifdef AES_MIXCOL_INV_EN
  aes_col_t w_inv;

  // 0e,0b,0d,09 circulant
  assign w_inv = {gf_mule(w_b0) ^ gf_mulb(w_b1) ^ gf_muld(w_b2) ^ gf_mul9(w_b3),
                  gf_mul9(w_b0) ^ gf_mule(w_b1) ^ gf_mulb(w_b2) ^ gf_muld(w_b3),
                  gf_muld(w_b0) ^ gf_mul9(w_b1) ^ gf_mule(w_b2) ^ gf_mulb(w_b3),
                  gf_mulb(w_b0) ^ gf_muld(w_b1) ^ gf_mul9(w_b2) ^ gf_mule(w_b3)};

  assign col_out = inv ? w_inv : w_fwd;
`else
  // Forward-only build: the select input is kept for a uniform interface
  logic w_unused_inv;
  assign w_unused_inv = inv;
  assign col_out      = w_fwd;
`endif

endmodule

// File: rtl/aes_mixcolumns_seq.sv
// Sequential AES (Inv)MixColumns, COLS_PER_CYCLE columns per cycle; inverse built only with AES_MIXCOL_INV_EN.
// Latency: accept at edge T, out_valid after edge T+4/COLS_PER_CYCLE.
// Backpressure: result held in DONE until out_ready; new input accepted in IDLE or in DONE during handoff.
module aes_mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int         N_GRP    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(N_GRP - 1);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("aes_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  mixcol_state_e          r_state, w_state_nxt;
  logic [1:0]             r_grp;
  logic [AES_STATE_W-1:0] r_work;
  logic                   r_inv;
  logic                   w_accept;
  logic                   w_last_grp;
  logic                   w_inv_in;
  aes_col_t               w_col_in  [COLS_PER_CYCLE];
  aes_col_t               w_col_out [COLS_PER_CYCLE];

`ifdef AES_MIXCOL_INV_EN
  assign w_inv_in = in_inv;
`else
  logic w_unused_in_inv;
  assign w_unused_in_inv = in_inv;
  assign w_inv_in        = 1'b0;
`endif

  assign w_accept   = in_valid && in_ready;
  assign w_last_grp = (r_grp == LAST_GRP);

  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
      assign w_col_in[j] = r_work[(int'(r_grp) * COLS_PER_CYCLE + j) * AES_COL_W +: AES_COL_W];
      aes_mixcol_col u_col (
        .col     (w_col_in[j]),
        .inv     (r_inv),
        .col_out (w_col_out[j])
      );
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; outputs forced low while reset is applied
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    out_state   = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last_grp) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_state = r_work;
        if (out_ready) begin
          in_ready    = 1'b1;
          w_state_nxt = in_valid ? BUSY : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_state = '0;
    end
  end

  // Capture on accept, then transform one column group per BUSY cycle in place
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_grp  <= 2'd0;
      r_inv  <= 1'b0;
    end else if (w_accept) begin
      r_work <= in_state;
      r_inv  <= w_inv_in;
      r_grp  <= 2'd0;
    end else if (r_state == BUSY) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        r_work[(int'(r_grp) * COLS_PER_CYCLE + j) * AES_COL_W +: AES_COL_W] <= w_col_out[j];
      end
      r_grp <= w_last_grp ? 2'd0 : r_grp + 2'd1;
    end
  end

endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Self-checking bench for aes_mixcolumns_seq against a matrix-over-GF(2^8) reference model.
// Latency: checks out_valid arrives exactly 4/CPC cycles after accept.
// Backpressure: exercises DONE stall, back-to-back overlap and mid-operation reset.
module tb_aes_mixcolumns_seq;

  parameter int CPC = 4;
  localparam int N  = 4 / CPC;
`ifdef AES_MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_mixcolumns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // Carry-less product then reduction by 0x11b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Each output byte r = sum_k coef[(k-r) mod 4] * b_k
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - r + 4) % 4], s[c*32 + (3-k)*8 +: 8]);
        res[c*32 + (3-r)*8 +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from IDLE: checks accept, latency, result and drain
  task automatic run_one(input logic [127:0] s, input logic inv, input string tag,
                         output logic [127:0] res);
    int lat;
    in_state  = s;
    in_inv    = inv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(N));
    res = out_state;
    chk({tag, "_result"}, out_state, ref_mix(s, inv && INV_EN));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk({tag, "_drained"}, 128'(out_valid), 128'(0));
  endtask

  logic [127:0] fips_in  = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
  logic [127:0] fips_out = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};

  initial begin
    logic [127:0] r, held, s;
    logic [127:0] stim [8];
    logic         sinv [8];
    logic [127:0] expq [$];
    logic [127:0] edge_pat [3];
    int idx, oidx, overlap, cyc, stable, hand, stale, g, wt;

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b0;

    // Reset state with reset still asserted
    tick(); tick();
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_out_state", out_state,       128'(0));
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 forward vector
    run_one(fips_in, 1'b0, "fips_fwd", r);
    chk("fips_fwd_const", r, fips_out);

    // Inverse of the FIPS output (forward again when the inverse is not built)
    run_one(fips_out, 1'b1, "fips_inv", r);
    chk("fips_inv_const", r, INV_EN ? fips_in : ref_mix(fips_out, 1'b0));

    // Backpressure in DONE: output frozen, no accept, single handoff on release
    s = rnd128();
    in_state = s; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wt = 0;
    while (!out_valid && wt < 20) begin tick(); wt++; end
    chk("bp_reach_done", 128'(out_valid), 128'(1));
    held = out_state;
    in_valid = 1'b1;
    in_state = rnd128();
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid && out_state === held && !in_ready && busy) stable++;
      tick();
    end
    chk("bp_stable_cycles", 128'(stable), 128'(10));
    chk("bp_result", held, ref_mix(s, 1'b0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hand = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid && out_ready) hand++;
      tick();
    end
    out_ready = 1'b0;
    chk("bp_single_handoff", 128'(hand), 128'(1));

    // Back-to-back random states with in_valid and out_ready held high
    for (int i = 0; i < 8; i++) begin
      stim[i] = rnd128();
      sinv[i] = 1'($urandom_range(0, 1));
      expq.push_back(ref_mix(stim[i], sinv[i] && INV_EN));
    end
    idx = 0; oidx = 0; overlap = 0; cyc = 0;
    out_ready = 1'b1;
    while (oidx < 8 && cyc < 200) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_state = stim[idx];
        in_inv   = sinv[idx];
      end
      #1;
      if (out_valid) begin
        chk($sformatf("b2b_out%0d", oidx), out_state, expq[oidx]);
        oidx++;
      end
      if (in_valid && in_ready) begin
        if (out_valid) overlap++;
        idx++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count",   128'(oidx),    128'(8));
    chk("b2b_overlap", 128'(overlap), 128'(7));

    // Reset in the middle of BUSY
    g = (N > 1) ? 1 : 0;
    in_state = rnd128(); in_inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < g; i++) tick();
    chk("mid_busy_before_rst", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out_state", out_state,       128'(0));
    chk("mid_rst_busy",      128'(busy),      128'(0));
    chk("mid_rst_in_ready",  128'(in_ready),  128'(1));
    stale = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      if (out_valid) stale++;
      tick();
    end
    chk("mid_rst_no_stale", 128'(stale), 128'(0));
    run_one(rnd128(), 1'b0, "post_rst", r);

    // Edge values, forward and inverse: constant columns are fixed points
    edge_pat[0] = {4{32'h00000000}};
    edge_pat[1] = {4{32'hffffffff}};
    edge_pat[2] = {4{32'hc6c6c6c6}};
    for (int p = 0; p < 3; p++) begin
      for (int v = 0; v < 2; v++) begin
        run_one(edge_pat[p], 1'(v), $sformatf("edge%0d_inv%0d", p, v), r);
        chk($sformatf("edge%0d_inv%0d_fixed", p, v), r, edge_pat[p]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
